// File: rtl/sw_alloc.sv
// Switch allocator: one round-robin arbiter per crossbar output, grants held until
// end-of-packet or an optional hold timeout.
module sw_alloc #(
  parameter int unsigned NP  = 4,
  parameter int unsigned TMO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] r0,
  input  logic [3:0] r1,
  input  logic [3:0] r2,
  input  logic [3:0] r3,
  input  logic       e0,
  input  logic       e1,
  input  logic       e2,
  input  logic       e3,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic [3:0] busy,
  output logic       tmo_ev
);

  typedef enum logic {StIdle, StHold} st_e;

  localparam logic [7:0] TmoLast = 8'(TMO - 1);

  st_e        state_q [NP];
  st_e        state_d [NP];
  logic [3:0] d_q     [NP];
  logic [3:0] d_d     [NP];
  logic [1:0] ptr_q   [NP];
  logic [1:0] ptr_d   [NP];
  logic [7:0] cnt_q   [NP];
  logic [7:0] cnt_d   [NP];
  logic [3:0] ack_q, ack_d;
  logic       tmo_q, tmo_d;

  logic [3:0] req     [NP];
  logic [3:0] elig    [NP];
  logic       win_vld [NP];
  logic [1:0] win_idx [NP];
  logic [3:0] eop;
  logic [3:0] holding;
  logic [1:0] idx;

  assign eop = {e3, e2, e1, e0};

  // Keep only the lowest set request bit, so an input can never win two outputs at once.
  always_comb begin
    req[0] = r0 & (~r0 + 4'd1);
    req[1] = r1 & (~r1 + 4'd1);
    req[2] = r2 & (~r2 + 4'd1);
    req[3] = r3 & (~r3 + 4'd1);
  end

  always_comb begin
    holding = '0;
    for (int j = 0; j < NP; j++) begin
      holding = holding | d_q[j];
    end
    for (int j = 0; j < NP; j++) begin
      for (int i = 0; i < NP; i++) begin
        elig[j][i] = req[i][j] & ~holding[i] & (state_q[j] == StIdle);
      end
    end
  end

  // Scan from the pointer downwards in priority; the last hit (smallest offset) wins.
  always_comb begin
    idx = '0;
    for (int j = 0; j < NP; j++) begin
      win_vld[j] = 1'b0;
      win_idx[j] = '0;
      for (int k = NP - 1; k >= 0; k--) begin
        idx = ptr_q[j] + 2'(k);
        if (elig[j][idx]) begin
          win_vld[j] = 1'b1;
          win_idx[j] = idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NP; j++) begin
        state_q[j] <= StIdle;
        d_q[j]     <= '0;
        ptr_q[j]   <= '0;
        cnt_q[j]   <= '0;
      end
      ack_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      for (int j = 0; j < NP; j++) begin
        state_q[j] <= state_d[j];
        d_q[j]     <= d_d[j];
        ptr_q[j]   <= ptr_d[j];
        cnt_q[j]   <= cnt_d[j];
      end
      ack_q <= ack_d;
      tmo_q <= tmo_d;
    end
  end

  always_comb begin
    ack_d = '0;
    tmo_d = 1'b0;
    for (int j = 0; j < NP; j++) begin
      state_d[j] = state_q[j];
      d_d[j]     = d_q[j];
      ptr_d[j]   = ptr_q[j];
      cnt_d[j]   = cnt_q[j];
      case (state_q[j])
        StIdle: begin
          if (win_vld[j]) begin
            state_d[j]          = StHold;
            d_d[j]              = 4'b0001 << win_idx[j];
            ptr_d[j]            = win_idx[j] + 2'd1;
            cnt_d[j]            = '0;
            ack_d[win_idx[j]]   = 1'b1;
          end
        end
        StHold: begin
          // End-of-packet wins over a timeout landing on the same edge.
          if (|(d_q[j] & eop)) begin
            state_d[j] = StIdle;
            d_d[j]     = '0;
          end else if ((TMO != 0) && (cnt_q[j] == TmoLast)) begin
            state_d[j] = StIdle;
            d_d[j]     = '0;
            tmo_d      = 1'b1;
          end else begin
            cnt_d[j] = cnt_q[j] + 8'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    d0     = d_q[0];
    d1     = d_q[1];
    d2     = d_q[2];
    d3     = d_q[3];
    busy   = {|d_q[3], |d_q[2], |d_q[1], |d_q[0]};
    a0     = ack_q[0];
    a1     = ack_q[1];
    a2     = ack_q[2];
    a3     = ack_q[3];
    tmo_ev = tmo_q;
  end

endmodule
